// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and default sizing.
package spi_slave_pkg;

    localparam int default_reg_width = 32;
    localparam int sync_depth        = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous input into the clk domain and flags its rising/falling edges.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter logic reset_val = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [sync_depth-1:0] stage;
    logic                  prev;

    // NOTE: resetting to the line's idle level keeps reset release from looking like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {sync_depth{reset_val}};
            prev  <= reset_val;
        end else begin
            stage <= {stage[sync_depth-2:0], din};
            prev  <= stage[sync_depth-1];
        end
    end

    assign sync = stage[sync_depth-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave oversampled by clk_system; reports each completed word with a data_valid pulse.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int reg_width = default_reg_width
) (
    input  logic                         clk_system,
    input  logic                         reset_system,
    input  logic                         cs,
    input  logic                         clk_spi,
    input  logic                         mosi,
    output logic                         miso,
    input  logic [reg_width-1:0]         data_inR,
    output logic [reg_width-1:0]         data_outR,
    output logic [$clog2(reg_width):0]   size_transfer,
    output logic                         data_valid,
    output logic                         busy
);

    localparam int cnt_w = $clog2(reg_width) + 1;

    logic cs_sync, cs_rise, cs_fall;
    logic sck_sync_unused, sck_rise, sck_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.reset_val(1'b1)) u_sync_cs (
        .clk   (clk_system),
        .rst_n (reset_system),
        .din   (cs),
        .sync  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.reset_val(1'b0)) u_sync_sck (
        .clk   (clk_system),
        .rst_n (reset_system),
        .din   (clk_spi),
        .sync  (sck_sync_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // Same depth as the clock path, so mosi lines up with the detected sck edge.
    spi_sync_edge #(.reset_val(1'b0)) u_sync_mosi (
        .clk   (clk_system),
        .rst_n (reset_system),
        .din   (mosi),
        .sync  (mosi_sync),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    state_t               state, state_next;
    logic [reg_width-1:0] tx_shift, rx_shift;
    logic [cnt_w-1:0]     bit_cnt;

    always_ff @(posedge clk_system or negedge reset_system) begin
        if (!reset_system) state <= IDLE;
        else               state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sck edges only count while cs is held low and no cs rise is pending.
    always_ff @(posedge clk_system or negedge reset_system) begin
        if (!reset_system) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            data_outR     <= '0;
            size_transfer <= '0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shift <= data_inR;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!cs_rise && !cs_sync) begin
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[reg_width-2:0], mosi_sync};
                            if (bit_cnt != cnt_w'(reg_width)) bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sck_fall) tx_shift <= {tx_shift[reg_width-2:0], 1'b0};
                    end
                end
                DONE: begin
                    data_outR     <= rx_shift;
                    size_transfer <= bit_cnt;
                    data_valid    <= 1'b1;
                    busy          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign miso = busy & tx_shift[reg_width-1];

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The parameter list SHALL be: reg_width, default 32, shift register and data word width in bits.
REQ-002 The port list SHALL be: clk_system  input  1  system clock; all logic on its rising edge.
REQ-003 The port list SHALL continue: reset_system  input  1  asynchronous, active-low reset.
REQ-004 The port list SHALL continue: cs  input  1  SPI chip select from master, active-low, asynchronous to clk_system.
REQ-005 The port list SHALL continue: clk_spi  input  1  SPI serial clock from master, mode 0 (idle low), asynchronous.
REQ-006 The port list SHALL continue: mosi  input  1  serial data from master, MSB first.
REQ-007 The port list SHALL continue: miso  output  1  serial data to master, MSB first.
REQ-008 The port list SHALL continue: data_inR  input  reg_width  word returned to master; sampled at transfer start.
REQ-009 The port list SHALL continue: data_outR  output  reg_width  last received word, right-aligned.
REQ-010 The port list SHALL continue: size_transfer  output  $clog2(reg_width)+1  bit count of last completed transfer.
REQ-011 The port list SHALL continue: data_valid  output  1  one-cycle pulse when data_outR/size_transfer update.
REQ-012 The port list SHALL end with: busy  output  1  high while a transfer is in progress.

Function
REQ-013 cs, clk_spi and mosi SHALL each pass through a 2-flop synchronizer; a third flop SHALL provide edge detection.
REQ-014 Operation SHALL be specified only for a clk_system frequency of at least 8x the clk_spi frequency.
REQ-015 The FSM SHALL have states IDLE, ACTIVE and DONE.
REQ-016 In IDLE, a synchronized cs falling edge SHALL: load data_inR into the tx shift register, clear the bit counter, assert busy and enter ACTIVE.
REQ-017 In ACTIVE, each synchronized clk_spi rising edge SHALL shift synchronized mosi into the rx shift register LSB (rx <= {rx[reg_width-2:0], mosi}) and increment the bit counter.
REQ-018 In ACTIVE, each synchronized clk_spi falling edge SHALL shift the tx register left by one bit, filling 0.
REQ-019 miso SHALL equal the tx register MSB while busy and 0 otherwise; the MSB SHALL be valid within 3 clk_system cycles of the cs fall.
REQ-020 The bit counter SHALL saturate at reg_width; received bits beyond reg_width SHALL keep only the last reg_width bits, and tx SHALL shift out zeros.
REQ-021 In ACTIVE, a synchronized cs rising edge SHALL enter DONE.
REQ-022 DONE SHALL last one cycle: register rx into data_outR and the counter into size_transfer, pulse data_valid, deassert busy and return to IDLE.
REQ-023 A cs rise with zero bits received SHALL still pulse data_valid, with size_transfer=0 and data_outR=0.
REQ-024 When cs rises and clk_spi edges occur in the same synchronized cycle, the cs rise SHALL take priority and the clk_spi edge SHALL be ignored.
REQ-025 clk_spi edges while in IDLE, or while synchronized cs is high, SHALL be ignored.
REQ-026 data_outR and size_transfer SHALL hold their values until the next DONE.

Reset
REQ-027 When reset_system is low, the block SHALL set: data_outR=0, size_transfer=0, data_valid=0, busy=0, miso=0, FSM=IDLE, shift registers=0.
REQ-028 The synchronizer flops SHALL reset to idle levels: cs=1, clk_spi=0, mosi=0. This prevents a false edge on reset release.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer without pulsing data_valid. After reset release, the block SHALL wait for a fresh cs fall.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, the default width constant (32) and the synchronizer depth constant (2).
REQ-031 A single sub-module, spi_sync_edge, SHALL implement one synchronizer with rise/fall detection. The block SHALL instantiate it for cs and clk_spi, and use only its synchronized output for mosi.

Verification
REQ-032 The bench SHALL drive cs low, then 32 mode-0 clocks with mosi=0xDEADBEEF, then cs high, with data_inR=0xCAFEF00D -> miso stream 0xCAFEF00D, data_outR=0xDEADBEEF, size_transfer=32, one data_valid pulse.
REQ-033 The bench SHALL run an 8-bit transfer of 0xA5 -> data_outR=0x000000A5, size_transfer=8; miso carries data_inR[31:24].
REQ-034 The bench SHALL run a 40-bit transfer of 0x12_3456789A -> data_outR=0x3456789A, size_transfer=32, miso zeros after bit 32.
REQ-035 The bench SHALL toggle cs low then high with no clk_spi edges -> data_valid pulse, size_transfer=0, data_outR=0.
REQ-036 The bench SHALL assert reset_system after 16 bits of a 32-bit transfer, then release it and run a full transfer of 0x0F0F0F0F -> no data_valid for the aborted transfer; second transfer yields data_outR=0x0F0F0F0F.
REQ-037 The bench SHALL toggle clk_spi 10 times with cs high -> busy stays 0, no data_valid, outputs unchanged.
